// File: rtl/cmp_result_stage.sv
// Result stage after the unsigned magnitude comparator: signed fixup,
// compare-op decode, and a small valid/ready result buffer.
module cmp_result_stage #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic             lt_i,
    input  logic             eq_i,
    input  logic             gt_i,
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic             flag_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o,
    input  logic             clear_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        OP_EQ    = 3'b000,
        OP_NE    = 3'b001,
        OP_SLTU  = 3'b010,
        OP_SLT   = 3'b011,
        OP_SGEU  = 3'b100,
        OP_SGE   = 3'b101,
        OP_CMP3U = 3'b110,
        OP_CMP3S = 3'b111
    } op_e;

    typedef struct packed {
        logic [31:0]      result;
        logic             flag;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    entry_t        mem_q [DEPTH];

    logic   push, pop;
    logic   s_lt, s_eq;
    logic   one_hot;
    entry_t dec;
    entry_t head;

    assign in_ready_o  = (count_q != FULL) & ~rst_i;
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Differing sign bits decide the signed order on their own.
    always_comb begin
        s_lt = lt_i;
        s_eq = eq_i;
        if (a_msb_i != b_msb_i) begin
            s_lt = a_msb_i;
            s_eq = 1'b0;
        end
    end

    assign one_hot = ( lt_i & ~eq_i & ~gt_i) |
                     (~lt_i &  eq_i & ~gt_i) |
                     (~lt_i & ~eq_i &  gt_i);

    always_comb begin
        dec        = '0;
        dec.tag    = tag_i;
        unique case (op_e'(op_i))
            OP_EQ:   dec.flag = eq_i;
            OP_NE:   dec.flag = ~eq_i;
            OP_SLTU: dec.flag = lt_i;
            OP_SLT:  dec.flag = s_lt;
            OP_SGEU: dec.flag = ~lt_i;
            OP_SGE:  dec.flag = ~s_lt;
            OP_CMP3U: begin
                dec.flag = ~eq_i;
            end
            OP_CMP3S: begin
                dec.flag = ~s_eq;
            end
            default: dec.flag = 1'b0;
        endcase
        dec.result = {31'b0, dec.flag};
        // Three-way result: eq wins over lt, anything else reads as greater.
        if (op_i == OP_CMP3U) begin
            dec.result = eq_i ? 32'd0 : (lt_i ? 32'd1 : 32'd2);
        end else if (op_i == OP_CMP3S) begin
            dec.result = s_eq ? 32'd0 : (s_lt ? 32'd1 : 32'd2);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push & ~pop) begin
            count_d = count_q + CW'(1);
        end else if (pop & ~push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (push & ~one_hot) begin
            err_d = 1'b1;
        end else if (clear_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    // Empty slots are masked so stale entries never leak after reset or drain.
    assign head     = mem_q[rd_ptr_q];
    assign result_o = out_valid_o ? head.result : '0;
    assign flag_o   = out_valid_o ? head.flag : 1'b0;
    assign tag_o    = out_valid_o ? head.tag : '0;
    assign err_o    = err_q;

endmodule

// File: doc/cmp_result_stage.md
# cmp_result_stage

Registered result stage placed directly downstream of the 32-bit unsigned magnitude comparator. It consumes the comparator's raw `lt`/`eq`/`gt` flags and the operand sign bits, applies signed correction, and decodes the requested compare operation into a 32-bit ALU result and a 1-bit branch flag. Results are delivered through a valid/ready FIFO of `DEPTH` entries so the comparator side never stalls on a slow consumer until the buffer is full.

## Interface
- `TAG_W`, 4, width of the opaque tag carried alongside each operation
- `DEPTH`, 2, result buffer entries; power of two, ≥ 2
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `in_valid_i`  in  1  upstream has a compare result to deliver
- `in_ready_o`  out  1  stage can accept; `(count != DEPTH) & ~rst_i`
- `op_i`  in  3  operation select (see Operation)
- `lt_i`, `eq_i`, `gt_i`  in  1 each  unsigned compare flags from the comparator
- `a_msb_i`, `b_msb_i`  in  1 each  bit 31 of operands a and b
- `tag_i`  in  TAG_W  tag, returned unchanged with the result
- `out_valid_o`  out  1  head entry valid
- `out_ready_i`  in  1  downstream accepts head entry
- `result_o`  out  32  ALU result of head entry
- `flag_o`  out  1  branch/condition flag of head entry
- `tag_o`  out  TAG_W  tag of head entry
- `err_o`  out  1  sticky: an accepted input had non-one-hot `{lt_i,eq_i,gt_i}`
- `clear_i`  in  1  synchronous clear of `err_o`

## Operation
- Accept when `in_valid_i & in_ready_o`; pop when `out_valid_o & out_ready_i`.
- Signed correction: if `a_msb_i != b_msb_i`, then `s_lt = a_msb_i`, `s_gt = b_msb_i`, `s_eq = 0`; otherwise `s_* = unsigned flags`.
- Op decode (flag; result = `{31'b0, flag}` unless noted):
  - 000 EQ: `eq`; 001 NE: `~eq`
  - 010 SLTU: `lt`; 011 SLT: `s_lt`
  - 100 SGEU: `~lt`; 101 SGE: `~s_lt`
  - 110 CMP3U: result = 0 if `eq`, 1 if `lt`, else 2; flag = `~eq`
  - 111 CMP3S: as 110 using `s_*` flags
- Decode happens before the write; the buffer stores `{result, flag, tag}` only.
- Priority for non-one-hot flags: `eq` over `lt` over `gt`, for both CMP3 and boolean ops (boolean ops use the listed flag directly). Such an accept sets `err_o` on the same edge.
- Buffer: circular, write pointer, read pointer, `count` in 0..DEPTH; pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance. Allowed at any count < DEPTH. At count == DEPTH, `in_ready_o` = 0, so only a pop occurs.
- `clear_i` and a setting error in the same cycle: set wins (`err_o` = 1).

## Timing
- Latency: accepted on edge N → `out_valid_o` = 1 and head outputs valid after edge N (when the buffer was empty).
- Throughput: one op per cycle with `out_ready_i` held high; no bubbles.
- `out_valid_o`, `result_o`, `flag_o`, `tag_o` come from registers/buffer, with no combinational path from `in_*`. `in_ready_o` depends only on `count` and `rst_i`, not on `out_ready_i`.
- Head outputs hold stable while `out_valid_o & ~out_ready_i`.
- Reset (asynchronous assert, at any time including mid-stream):
  - count, pointers, `err_o`, `out_valid_o` = 0
  - `result_o`, `tag_o`, `flag_o` = 0
  - buffered entries are discarded
  - `in_ready_o` = 0 while `rst_i` is high, and 1 on the first cycle after deassert.

## Test plan
- EQ/NE/SLTU/SGEU with a=0x00000005, b=0x00000007 (lt=1): flags 0/1/1/0, results 0x0/0x1/0x1/0x0, tags returned in order, one result per cycle.
- Signed correction with a=0xFFFFFFFF, b=0x00000001 (gt=1, a_msb=1, b_msb=0):
  - SLT → 0x1, SLTU → 0x0, SGE → 0x0
  - CMP3S → 0x1, CMP3U → 0x2
- Backpressure: hold `out_ready_i`=0 and push 3 ops. Only DEPTH=2 are accepted; `in_ready_o`=0 after the 2nd. Release: results drain in order, and `in_ready_o` returns to 1 the cycle after the first pop.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, the pointers wrap, and all tags exit in order.
- Illegal flags `{lt,eq,gt}`=3'b110 with CMP3U: result 0x0, `err_o`=1 and sticky. `clear_i` with no error clears `err_o` next cycle; `clear_i` together with a new bad input leaves `err_o`=1.
- Assert `rst_i` mid-cycle with 2 buffered entries: `out_valid_o`, `err_o` and `in_ready_o` drop immediately without waiting for a clock edge. After deassert, the first new op appears with latency 1 and no stale data.
